// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALUOp/Branch encodings and the packed control bundle.
// Combinational helpers only; no state, no flow control.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BNE  = 2'b01,
    BR_BEQ  = 2'b11
  } branch_e;

  typedef struct packed {
    logic       regdst;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
    logic [1:0] branch;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Reference controller decode, kept next to the encodings it depends on.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (opcode)
      OP_RTYPE: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OP_BEQ: begin
        c.aluop  = ALUOP_SUB;
        c.branch = BR_BEQ;
      end
      OP_BNE: begin
        c.aluop  = ALUOP_SUB;
        c.branch = BR_BNE;
      end
      default: c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

  // Fields that only matter for a register write are forced to 0 when no write happens.
  function automatic ctrl_t sanitize_ctrl(input ctrl_t c);
    ctrl_t s;
    s = c;
    if (!c.regwrite) begin
      s.regdst   = 1'b0;
      s.memtoreg = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detect against the registered EX stage; flush masks the stall.
// Zero latency; the stall it raises is the backpressure to PC, IF/ID and the controller.
module load_use_detector #(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  output logic             hz,
  output logic             stall
);

  logic rt_nonzero;
  logic rt_match;

  // A load into $0 never produces a value worth waiting for.
  assign rt_nonzero = (ex_rt != '0);
  assign rt_match   = (ex_rt == id_rs) || (ex_rt == id_rt);
  assign hz         = ex_valid && ex_memread && rt_nonzero && rt_match;
  assign stall      = hz && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and saturating perf counters.
// One cycle ID->EX; stall_o holds the front end for exactly one cycle while a bubble enters EX.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_regdst,
  input  logic              id_memread,
  input  logic              id_memtoreg,
  input  logic              id_memwrite,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic [1:0]        id_aluop,
  input  logic [1:0]        id_branch,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid,
  output logic              ex_regdst,
  output logic              ex_memread,
  output logic              ex_memtoreg,
  output logic              ex_memwrite,
  output logic              ex_alusrc,
  output logic              ex_regwrite,
  output logic [1:0]        ex_aluop,
  output logic [1:0]        ex_branch,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [5:0]        ex_funct,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hz;

  always_comb begin
    id_ctrl          = CTRL_BUBBLE;
    id_ctrl.regdst   = id_regdst;
    id_ctrl.memread  = id_memread;
    id_ctrl.memtoreg = id_memtoreg;
    id_ctrl.memwrite = id_memwrite;
    id_ctrl.alusrc   = id_alusrc;
    id_ctrl.regwrite = id_regwrite;
    id_ctrl.aluop    = id_aluop;
    id_ctrl.branch   = id_branch;
  end

  load_use_detector #(
    .REG_W (REG_W)
  ) u_load_use_detector (
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl.memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .flush      (flush_i),
    .hz         (hz),
    .stall      (stall_o)
  );

  // Flush and stall both insert a fully zeroed bubble; flush takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl    <= CTRL_BUBBLE;
      ex_valid   <= 1'b0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_funct   <= '0;
    end else if (flush_i || hz) begin
      ex_ctrl    <= CTRL_BUBBLE;
      ex_valid   <= 1'b0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_funct   <= '0;
    end else begin
      ex_ctrl    <= sanitize_ctrl(id_ctrl);
      ex_valid   <= 1'b1;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_funct   <= id_funct;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush_i && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
      if (stall_o && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign ex_regdst   = ex_ctrl.regdst;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_aluop    = ex_ctrl.aluop;
  assign ex_branch   = ex_ctrl.branch;

  // The bubble clears ex_memread, so a second back-to-back stall means the detector is broken.
  a_single_cycle_stall : assert property (
    @(posedge clk) disable iff (rst) stall_o |=> !stall_o
  );

  a_ctrl_known_on_write : assert property (
    @(posedge clk) disable iff (rst)
      id_regwrite |-> !$isunknown({id_regdst, id_memread, id_memtoreg, id_memwrite,
                                   id_alusrc, id_aluop, id_branch})
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a transaction-level model of the EX slot.
module tb_id_ex_stage;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic        regdst, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [1:0]  aluop, branch;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic        flush;
  } instr_t;

  logic clk, rst;
  logic id_regdst, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
  logic [1:0] id_aluop, id_branch;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic [5:0] id_funct;
  logic flush_i, stall_o, ex_valid;
  logic ex_regdst, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0] ex_aluop, ex_branch;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_rd;
  logic [5:0] ex_funct;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_regdst(id_regdst), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_aluop(id_aluop), .id_branch(id_branch),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .flush_i(flush_i), .stall_o(stall_o), .ex_valid(ex_valid),
    .ex_regdst(ex_regdst), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_aluop(ex_aluop), .ex_branch(ex_branch),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  instr_t cur;
  instr_t m_ex;      // what EX should hold
  bit     m_valid;
  int     m_scnt, m_fcnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t nop();
    instr_t i;
    i = '{default: '0};
    return i;
  endfunction

  function automatic instr_t f_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [31:0] a, input logic [31:0] b);
    instr_t i = nop();
    i.regdst = 1; i.regwrite = 1; i.aluop = 2'b10; i.funct = 6'h20;
    i.rs = rs; i.rt = rt; i.rd = rd; i.rs_data = a; i.rt_data = b;
    return i;
  endfunction

  function automatic instr_t f_lw(input logic [4:0] rs, input logic [4:0] rt);
    instr_t i = nop();
    i.memread = 1; i.memtoreg = 1; i.alusrc = 1; i.regwrite = 1;
    i.rs = rs; i.rt = rt; i.imm = 32'h10;
    return i;
  endfunction

  function automatic instr_t f_rand();
    instr_t i;
    i.regdst = 1'($urandom); i.memread = 1'($urandom); i.memtoreg = 1'($urandom);
    i.memwrite = 1'($urandom); i.alusrc = 1'($urandom); i.regwrite = 1'($urandom);
    i.aluop = 2'($urandom); i.branch = 2'($urandom);
    i.rs_data = $urandom; i.rt_data = $urandom; i.imm = $urandom;
    i.rs = 5'($urandom_range(0, 3)); i.rt = 5'($urandom_range(0, 3)); i.rd = 5'($urandom);
    i.funct = 6'($urandom);
    i.flush = ($urandom_range(0, 7) == 0);
    return i;
  endfunction

  function automatic bit model_hazard(input instr_t id);
    return m_valid && m_ex.memread && (m_ex.rt != 0) && (m_ex.rt == id.rs || m_ex.rt == id.rt);
  endfunction

  task automatic apply(input instr_t i);
    cur = i;
    id_regdst = i.regdst; id_memread = i.memread; id_memtoreg = i.memtoreg;
    id_memwrite = i.memwrite; id_alusrc = i.alusrc; id_regwrite = i.regwrite;
    id_aluop = i.aluop; id_branch = i.branch;
    id_rs_data = i.rs_data; id_rt_data = i.rt_data; id_imm = i.imm;
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; id_funct = i.funct;
    flush_i = i.flush;
  endtask

  task automatic model_reset();
    m_ex = nop(); m_valid = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic check_ex(input string pfx);
    check({pfx, "_ctrl"}, {ex_regdst, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite,
                           ex_aluop, ex_branch},
          {m_ex.regdst, m_ex.memread, m_ex.memtoreg, m_ex.memwrite, m_ex.alusrc, m_ex.regwrite,
           m_ex.aluop, m_ex.branch});
    check({pfx, "_valid"}, ex_valid, m_valid);
    check({pfx, "_rs_data"}, ex_rs_data, m_ex.rs_data);
    check({pfx, "_rt_data"}, ex_rt_data, m_ex.rt_data);
    check({pfx, "_imm"}, ex_imm, m_ex.imm);
    check({pfx, "_regs"}, {ex_rs, ex_rt, ex_rd}, {m_ex.rs, m_ex.rt, m_ex.rd});
    check({pfx, "_funct"}, ex_funct, m_ex.funct);
    check({pfx, "_stall_cnt"}, stall_cnt, m_scnt);
    check({pfx, "_flush_cnt"}, flush_cnt, m_fcnt);
  endtask

  task automatic pre_check();
    @(negedge clk);
    check("stall_o", stall_o, model_hazard(cur) && !cur.flush);
  endtask

  task automatic post();
    bit hz;
    hz = model_hazard(cur);
    @(posedge clk);
    if (cur.flush) begin
      m_ex = nop(); m_valid = 0;
      if (m_fcnt < CNT_MAX) m_fcnt++;
    end else if (hz) begin
      m_ex = nop(); m_valid = 0;
      if (m_scnt < CNT_MAX) m_scnt++;
    end else begin
      m_ex = cur; m_valid = 1;
      if (!cur.regwrite) begin
        m_ex.regdst = 0; m_ex.memtoreg = 0;
      end
    end
    #1;
    check_ex("ex");
  endtask

  task automatic step(input instr_t i);
    apply(i);
    pre_check();
    post();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_stall_o", stall_o, 0);
    check_ex("rst");
    rst = 1'b0;
    #1;
  endtask

  initial begin
    instr_t dep, t;
    rst = 1'b1;
    model_reset();
    apply(nop());
    @(posedge clk);
    #1;
    check("init_stall_o", stall_o, 0);
    check_ex("init");
    rst = 1'b0;

    // Five load-use stalls, each followed by the held instruction being captured.
    for (int k = 0; k < 5; k++) begin
      step(f_lw(5'd1, 5'd8));
      dep = f_rtype(5'd8, 5'd2, 5'd3, 32'h11 + k, 32'h22);
      step(dep);
      check("lu_bubble_valid", ex_valid, 0);
      step(dep);
      check("lu_capture_valid", ex_valid, 1);
    end
    check("lu_stall_cnt5", stall_cnt, 5);

    // Asynchronous reset mid-cycle with ex_valid=1 and stall_cnt=5.
    #3;
    reset_pulse();
    check("rst_counter_zero", {stall_cnt, flush_cnt}, 0);

    step(f_rtype(5'd4, 5'd5, 5'd6, 32'h0000_0007, 32'h0000_0003));
    check("rtype_aluop", ex_aluop, 2'd2);
    check("rtype_regdst", ex_regdst, 1);
    check("rtype_rs_data", ex_rs_data, 32'h7);
    check("rtype_rt_data", ex_rt_data, 32'h3);

    step(f_lw(5'd1, 5'd0));
    step(f_rtype(5'd0, 5'd0, 5'd9, 32'h1, 32'h2));
    check("r0_no_stall_valid", ex_valid, 1);

    step(f_lw(5'd1, 5'd8));
    t = f_rtype(5'd8, 5'd2, 5'd3, 32'h5, 32'h6);
    t.flush = 1;
    step(t);
    check("flush_prio_fcnt", flush_cnt, 1);
    check("flush_prio_scnt", stall_cnt, 0);
    check("flush_prio_valid", ex_valid, 0);

    t = nop();
    t.memwrite = 1; t.alusrc = 1; t.regwrite = 0;
    t.regdst = 1'bx; t.memtoreg = 1'bx; t.rs = 5'd2; t.rt = 5'd7; t.imm = 32'h40;
    step(t);
    check("sw_regdst", ex_regdst, 0);
    check("sw_memtoreg", ex_memtoreg, 0);
    check("sw_memwrite", ex_memwrite, 1);
    check("sw_alusrc", ex_alusrc, 1);

    // Reset while stall_o is high; the next clean edge captures normally.
    step(f_lw(5'd1, 5'd9));
    dep = f_rtype(5'd9, 5'd1, 5'd4, 32'hA, 32'hB);
    apply(dep);
    pre_check();
    reset_pulse();
    post();
    check("post_rst_capture", ex_valid, 1);

    for (int k = 0; k < 20; k++) begin
      t = f_rand();
      t.flush = 1;
      step(t);
    end
    check("flush_saturate", flush_cnt, 15);

    for (int k = 0; k < 400; k++) begin
      t = f_rand();
      if (k % 5 == 0) t.memread = 1;
      step(t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary that consumes the decode controller's control outputs and the register-file and immediate operands, and presents them to EX one cycle later.
- Contains load-use hazard detection. Its stall output drives the controller's Controller_Write bubble input, PC write enable and IF/ID write enable.
- Handles branch flush and bubble insertion.
- Keeps saturating stall and flush performance counters.

Parameters:
- DATA_W, 32, operand and immediate width
- REG_W, 5, register specifier width
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_regdst, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  controller outputs
- id_aluop  in  2  controller ALUOp (00 add, 01 sub/compare, 10 R-type funct)
- id_branch  in  2  controller Branch (00 none, 11 BEQ, 01 BNE)
- id_rs_data, id_rt_data, id_imm  in  DATA_W each  read operands and sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_W each  register specifiers
- id_funct  in  6  funct field
- flush_i  in  1  branch taken, resolved downstream; kills the ID instruction
- stall_o  out  1  load-use stall; to Controller_Write, ~pc_write, ~if_id_write
- ex_valid  out  1  EX holds a real instruction
- ex_* (one per id_* input)  out  same widths  registered copies
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (asynchronous, clock-independent): every registered output, including ex_valid and both counters, goes to 0. stall_o is then 0 because ex_memread=0.
- Hazard detection is combinational and uses only registered EX state:
  - hz = ex_valid & ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt))
  - stall_o = hz & ~flush_i
- Each rising edge, in priority order:
  1. flush_i=1: bubble. All control fields are 0, ex_valid=0, data and specifier fields are 0. flush_cnt increments.
  2. stall_o=1: bubble, identical to case 1. stall_cnt increments.
  3. Otherwise: capture all id_* inputs and set ex_valid=1.
- Sanitising on capture:
  - If id_regwrite=0, store ex_regdst=0 and ex_memtoreg=0. This removes the controller's don't-care values on BEQ/BNE/SW.
  - Any X/Z on an id_* control input with id_regwrite=1 is a design error; an assertion flags it.
- Latency: exactly 1 cycle from ID to EX. There is no internal buffering beyond one entry.
- A stall lasts exactly 1 cycle, because the inserted bubble clears ex_memread. An assertion checks that stall_o is never high on two consecutive cycles.
- Simultaneous flush_i and hz: flush wins, stall_o=0, only flush_cnt increments.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset asserted mid-stall or mid-flush: all state clears immediately. After deassertion, the first edge with no flush or stall captures normally.
- Register $0 as the load destination never stalls.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (R-type 0, BEQ 4, BNE 5, LW 35, SW 43)
  - ALUOp encodings and Branch encodings
  - a packed ctrl_t bundling the 10 control bits, with a CTRL_BUBBLE all-zero constant
- One sub-module, load_use_detector: combinational hz/stall_o logic, kept separate for reuse by a future forwarding unit.
- Pipeline register and counters stay in id_ex_stage.

Test Plan:
- Reset: assert rst mid-stream with ex_valid=1, stall_cnt=5 -> all ex_* outputs, ex_valid and both counters read 0 before the next clock edge.
- R-type pass-through: id_regwrite=1, id_aluop=2, id_regdst=1, rs_data=0x0000_0007, rt_data=0x0000_0003 -> the next cycle shows ex_aluop=2, ex_regdst=1, the same data, ex_valid=1, stall_o=0.
- Load-use: EX holds LW with ex_rt=8 and ID has id_rs=8 -> stall_o=1 for exactly one cycle and EX becomes a bubble with stall_cnt=1. The next edge captures the held ID instruction.
- $0 load and flush priority:
  - LW with ex_rt=0 and id_rs=0 -> stall_o=0.
  - Same hazard with ex_rt=8 plus flush_i=1 -> stall_o=0, flush_cnt=1, stall_cnt unchanged, ex_valid=0.
- Sanitise: SW with id_regwrite=0, id_regdst=X, id_memtoreg=X -> ex_regdst=0, ex_memtoreg=0, ex_memwrite=1, ex_alusrc=1.
- Saturation: CNT_W=4 with 20 consecutive flushes -> flush_cnt holds at 15.
